// File: rtl/flash_multi.sv
// Multi-channel switch-triggered LED flasher.
// Each channel synchronises and debounces its switch, then plays a burst of on/off flashes.
module flash_multi #(
  parameter int CH          = 1,
  parameter int DEB_CYCLES  = 62500,
  parameter int ON_CYCLES   = 1562500,
  parameter int OFF_CYCLES  = 1562500,
  parameter int FLASH_COUNT = 3,
  parameter int RETRIGGER   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] ld,
  output logic [CH-1:0] done,
  output logic          busy
);

  localparam int PMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int FW   = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(OFF_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(FLASH_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  logic [CH-1:0] active;

  assign busy = |active;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          s1, s2, db, db_q, trig;
    logic [DW-1:0] dcnt;
    state_t        state, state_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [FW-1:0] fcnt, fcnt_nxt;
    logic          done_r, done_nxt;
    logic          ld_ch, active_ch;

    // A level change is accepted only after it has been stable at s2 for DEB_CYCLES cycles
    always_ff @(posedge clk) begin
      if (rst) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        db   <= 1'b0;
        db_q <= 1'b0;
        dcnt <= '0;
      end else begin
        s1   <= sw[i];
        s2   <= s1;
        db_q <= db;
        if (s2 == db) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          db   <= s2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end

    assign trig = db & ~db_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        pcnt   <= '0;
        fcnt   <= '0;
        done_r <= 1'b0;
      end else begin
        state  <= state_nxt;
        pcnt   <= pcnt_nxt;
        fcnt   <= fcnt_nxt;
        done_r <= done_nxt;
      end
    end

    // Retrigger restarts the burst and wins over the terminal-count transition
    always_comb begin
      state_nxt = state;
      pcnt_nxt  = pcnt;
      fcnt_nxt  = fcnt;
      done_nxt  = 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            state_nxt = ON;
            pcnt_nxt  = '0;
            fcnt_nxt  = '0;
          end
        end
        ON: begin
          if (pcnt == ON_LAST) begin
            state_nxt = OFF;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + PW'(1);
          end
        end
        OFF: begin
          if (pcnt == OFF_LAST) begin
            pcnt_nxt = '0;
            if (fcnt == F_LAST) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ON;
              fcnt_nxt  = fcnt + FW'(1);
            end
          end else begin
            pcnt_nxt = pcnt + PW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          pcnt_nxt  = '0;
          fcnt_nxt  = '0;
        end
      endcase
      if (RETRIGGER != 0 && trig && state != IDLE) begin
        state_nxt = ON;
        pcnt_nxt  = '0;
        fcnt_nxt  = '0;
        done_nxt  = 1'b0;
      end
    end

    always_comb begin
      ld_ch     = (state == ON);
      active_ch = (state != IDLE);
    end

    assign ld[i]     = ld_ch;
    assign done[i]   = done_r;
    assign active[i] = active_ch;
  end

endmodule

// File: tb/tb_flash_multi.sv
// Scoreboard bench for flash_multi: three instances (short flashes, long no-retrigger, long retrigger)
// share the switch stimulus; an abstract timeline model predicts every cycle's outputs.
module tb_flash_multi;

  localparam int DEB = 4;
  localparam int FC  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw  = 2'b11;

  logic [1:0] ld_a, done_a, ld_b, done_b, ld_c, done_c;
  logic       busy_a, busy_b, busy_c;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;
  int done_cnt[3][2];

  logic [14:0] exp_q[$];

  int on_c[3]  = '{3, 8, 8};
  int off_c[3] = '{2, 8, 8};
  int rt_c[3]  = '{0, 0, 1};

  flash_multi #(.CH(2), .DEB_CYCLES(DEB), .ON_CYCLES(3), .OFF_CYCLES(2),
                .FLASH_COUNT(FC), .RETRIGGER(0)) dut_a (
    .clk(clk), .rst(rst), .sw(sw), .ld(ld_a), .done(done_a), .busy(busy_a));

  flash_multi #(.CH(2), .DEB_CYCLES(DEB), .ON_CYCLES(8), .OFF_CYCLES(8),
                .FLASH_COUNT(FC), .RETRIGGER(0)) dut_b (
    .clk(clk), .rst(rst), .sw(sw), .ld(ld_b), .done(done_b), .busy(busy_b));

  flash_multi #(.CH(2), .DEB_CYCLES(DEB), .ON_CYCLES(8), .OFF_CYCLES(8),
                .FLASH_COUNT(FC), .RETRIGGER(1)) dut_c (
    .clk(clk), .rst(rst), .sw(sw), .ld(ld_c), .done(done_c), .busy(busy_c));

  always #5 clk = ~clk;

  // Reference: a debounced level per channel, then each burst is just elapsed time since its trigger
  initial begin : model
    bit m_s1[2], m_s2[2], m_db[2], m_dbq[2], trig[2];
    int m_run[2];
    bit act[3][2];
    int t[3][2];
    bit dn[3][2];
    logic [14:0] e;
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_dbq[c] = 0; m_run[c] = 0;
    end
    for (int u = 0; u < 3; u++)
      for (int c = 0; c < 2; c++) begin
        act[u][c] = 0; t[u][c] = 0; dn[u][c] = 0;
      end
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int c = 0; c < 2; c++) begin
          m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_dbq[c] = 0; m_run[c] = 0;
        end
        for (int u = 0; u < 3; u++)
          for (int c = 0; c < 2; c++) begin
            act[u][c] = 0; t[u][c] = 0; dn[u][c] = 0;
          end
      end else begin
        for (int c = 0; c < 2; c++) begin
          trig[c]  = m_db[c] & ~m_dbq[c];
          m_dbq[c] = m_db[c];
          if (m_s2[c] != m_db[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
              m_db[c]  = m_s2[c];
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
          m_s2[c] = m_s1[c];
          m_s1[c] = sw[c];
        end
        for (int u = 0; u < 3; u++)
          for (int c = 0; c < 2; c++) begin
            dn[u][c] = 0;
            if (trig[c] && (!act[u][c] || rt_c[u] != 0)) begin
              act[u][c] = 1;
              t[u][c]   = 0;
            end else if (act[u][c]) begin
              t[u][c]++;
              if (t[u][c] == FC * (on_c[u] + off_c[u])) begin
                act[u][c] = 0;
                dn[u][c]  = 1;
              end
            end
          end
      end
      for (int u = 0; u < 3; u++) begin
        for (int c = 0; c < 2; c++) begin
          e[u*5 + 3 + c] = act[u][c] && ((t[u][c] % (on_c[u] + off_c[u])) < on_c[u]);
          e[u*5 + 1 + c] = dn[u][c];
        end
        e[u*5] = act[u][0] | act[u][1];
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    logic [14:0] e, a;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ld_c, done_c, busy_c, ld_b, done_b, busy_b, ld_a, done_a, busy_a};
        for (int u = 0; u < 3; u++) begin
          n_cmp++;
          if (a[u*5 +: 5] !== e[u*5 +: 5]) begin
            n_fail++;
            $display("[TB] FAIL scoreboard inst%0d cycle %0d: got ld=%b done=%b busy=%b, want ld=%b done=%b busy=%b",
                     u, cycle, a[u*5+3 +: 2], a[u*5+1 +: 2], a[u*5],
                     e[u*5+3 +: 2], e[u*5+1 +: 2], e[u*5]);
          end
        end
        for (int c = 0; c < 2; c++) begin
          if (done_a[c] === 1'b1) done_cnt[0][c]++;
          if (done_b[c] === 1'b1) done_cnt[1][c]++;
          if (done_c[c] === 1'b1) done_cnt[2][c]++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] s, input logic r, input int n);
    repeat (n) begin
      @(negedge clk);
      sw  = s;
      rst = r;
    end
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin : stimulus
    int base[3][2];
    logic [1:0] lvl;
    int run[2];
    for (int u = 0; u < 3; u++)
      for (int c = 0; c < 2; c++) done_cnt[u][c] = 0;

    $display("[TB] reset with switches held high");
    applyStimulus(2'b11, 1'b1, 3);
    applyStimulus(2'b11, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 30);

    $display("[TB] single press on channel 0");
    base = done_cnt;
    applyStimulus(2'b01, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 40);
    checkOutput("single_done_a0", done_cnt[0][0] - base[0][0], 1);
    checkOutput("single_done_a1", done_cnt[0][1] - base[0][1], 0);

    $display("[TB] glitch and bounce");
    base = done_cnt;
    applyStimulus(2'b01, 1'b0, 3);
    applyStimulus(2'b00, 1'b0, 10);
    for (int k = 0; k < 10; k++) applyStimulus((k % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 1);
    applyStimulus(2'b01, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 40);
    checkOutput("bounce_done_a0", done_cnt[0][0] - base[0][0], 1);

    $display("[TB] press, release, re-press during burst");
    base = done_cnt;
    applyStimulus(2'b01, 1'b0, 6);
    applyStimulus(2'b00, 1'b0, 6);
    applyStimulus(2'b01, 1'b0, 6);
    applyStimulus(2'b00, 1'b0, 60);
    checkOutput("noretrig_done_b0", done_cnt[1][0] - base[1][0], 1);
    checkOutput("retrig_done_c0", done_cnt[2][0] - base[2][0], 1);

    $display("[TB] reset during a burst");
    base = done_cnt;
    applyStimulus(2'b01, 1'b0, 8);
    applyStimulus(2'b01, 1'b1, 1);
    applyStimulus(2'b01, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 60);
    checkOutput("midreset_done_a0", done_cnt[0][0] - base[0][0], 1);

    $display("[TB] random switch activity");
    lvl = 2'b00;
    run[0] = 1;
    run[1] = 1;
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < 2; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          run[c] = $urandom_range(1, 12);
        end
      end
      applyStimulus(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1);
    end
    applyStimulus(2'b00, 1'b0, 50);
    applyStimulus(2'b00, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_multi.md
# flash_multi

Parametrised multi-channel switch-triggered LED flasher, successor to the single-channel flash block. Each channel synchronises and debounces its switch input. On a debounced rising edge it plays a burst of FLASH_COUNT on/off flashes with programmable on and off times. Retrigger behaviour is selectable. The block sits between the board switches and the LED pins in the top-level design.

## Interface
- CH, 1: number of independent channels (≥1).
- DEB_CYCLES, 62500: consecutive stable cycles needed to accept a switch level change (≥1).
- ON_CYCLES, 1562500: cycles the LED is lit per flash (≥1).
- OFF_CYCLES, 1562500: cycles the LED is dark after each flash, including the last (≥1).
- FLASH_COUNT, 3: flashes per burst (1..255).
- RETRIGGER, 0: 0 = press during a burst is ignored (not queued); 1 = press restarts the burst.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  CH  raw asynchronous switch inputs, active high.
- ld  output  CH  LED drives, active high.
- done  output  CH  one-cycle pulse per channel when a burst completes.
- busy  output  1  OR over all channels of (state != IDLE).

## Operation
- Per channel:
  - 2-flop synchroniser s1 <= sw, s2 <= s1.
  - Debounced level db, debounce counter dcnt.
  - State machine IDLE/ON/OFF, phase counter pcnt, flash counter fcnt.
- Debounce:
  - If s2 == db: dcnt <= 0.
  - Else if dcnt == DEB_CYCLES-1: db <= s2, dcnt <= 0.
  - Else: dcnt <= dcnt+1.
- Trigger = db & ~db_q, where db_q is db delayed one cycle. Falling edges of db cause nothing.
- IDLE: on trigger go to ON with pcnt = 0 and fcnt = 0.
- ON: pcnt counts 0..ON_CYCLES-1. At the terminal value, go to OFF with pcnt = 0.
- OFF: pcnt counts 0..OFF_CYCLES-1. At the terminal value:
  - If fcnt == FLASH_COUNT-1: go to IDLE and assert done for that cycle.
  - Else: fcnt+1, go to ON with pcnt = 0.
- Trigger in ON or OFF:
  - RETRIGGER=0: ignored.
  - RETRIGGER=1: go to ON with pcnt = 0 and fcnt = 0. This overrides the terminal-count transition in the same cycle, and done is not asserted.
- ld[i] = (state_i == ON), decoded from registered state only, so it is glitch-free.
- Counter widths: $clog2 of the largest count, minimum 1 bit. No wrap-around is reachable.
- Channels are fully independent. Simultaneous triggers on several channels are all honoured.

## Timing
- rst sampled high clears s1, s2, db, db_q, all counters, and state to IDLE. From the following cycle: ld = 0, done = 0, busy = 0.
- Reset mid-burst aborts the burst with no done pulse.
- A switch held high through reset is seen as a new press after release and goes through the full debounce.
- Latency: counting the first edge that samples sw = 1 as edge 0, with sw stable, db rises after edge 1+DEB_CYCLES and ld rises after edge 2+DEB_CYCLES.
- Burst length: FLASH_COUNT × (ON_CYCLES+OFF_CYCLES) cycles from ld rising to entry into IDLE. done is high in the first IDLE cycle.
- A level shorter than DEB_CYCLES cycles at s2 is rejected, and dcnt restarts on every bounce.

## Test plan
Bench parameters: CH=2, DEB_CYCLES=4, ON_CYCLES=3, OFF_CYCLES=2, FLASH_COUNT=2, RETRIGGER=0 unless stated.
- Reset: rst=1 for 3 cycles with sw=2'b11 -> ld=0, done=0, busy=0 throughout. After release, ld[0] and ld[1] both rise 6 edges after the first post-reset sampling edge.
- Single press: sw[0] held 20 cycles -> ld[0] = 1,1,1,0,0,1,1,1,0,0 then 0. done[0] pulses once, 10 cycles after ld rose. busy tracks the burst. ld[1]=0 and done[1]=0 throughout.
- Glitch/bounce: sw[0] high for 3 cycles -> no flash. Then sw[0] toggling every cycle for 10 cycles and held high -> exactly one burst, starting 6 edges after the final stable sample.
- No retrigger (ON_CYCLES=8, OFF_CYCLES=8): release then re-press inside the first flash, each level held 6 cycles -> exactly 2 flashes and one done pulse.
- Retrigger (RETRIGGER=1, same stimulus) -> burst restarts one cycle after the second trigger, giving 2 complete flashes after it. Exactly one done pulse, none for the aborted burst.
- Mid-burst reset: rst=1 for 1 cycle during ON with sw[0] held -> ld[0]=0 and busy=0 from the next cycle, no done pulse. A new burst starts 6 edges after reset release.
